alu_result_fifo: RTL and testbench

Downstream capture stage for the 16-bit adiabatic logic units (AND/OR/XOR slices): tracks which cycles carry a real operation through the fixed-latency gate pipeline, samples the unit output when that operation arrives, derives zero/negative flags and queues results in a small FIFO with a valid/ready handshake to the register-file write port. Credit-based issue gating guarantees every issued operation has a FIFO slot on arrival.

---
 rtl/alu_result_fifo_if.sv | 30 +++
 rtl/alu_result_fifo.sv | 117 +++++++++++
 tb/tb_alu_result_fifo.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_fifo_if.sv
// Issue/capture/drain handshake bundle between the ALU result FIFO and its neighbours.
interface alu_result_fifo_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic             issue;
   logic             issue_ready;
   logic [WIDTH-1:0] alu_out;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_zero;
   logic             out_neg;
   logic [CW-1:0]    count;
   logic             ovf_err;

   // FIFO side
   modport slave (
      input  issue, alu_out, out_ready,
      output issue_ready, out_valid, out_data, out_zero, out_neg, count, ovf_err
   );

   // Issuing unit / consumer side
   modport master (
      output issue, alu_out, out_ready,
      input  issue_ready, out_valid, out_data, out_zero, out_neg, count, ovf_err
   );
endinterface

// File: rtl/alu_result_fifo.sv
// Captures fixed-latency ALU results into a flagged FIFO; issue credit keeps a slot
// reserved for every operation in flight.
module alu_result_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned LAT   = 2
) (
   input logic               clkpos,
   input logic               rst,
   input logic               vdd,
   input logic               vss,
   alu_result_fifo_if.slave  bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   // LAT-1 stages after the accept edge put the capture edge at the end of cycle c+LAT-1
   localparam int unsigned TW = (LAT > 1) ? LAT - 1 : 1;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             zero;
      logic             neg;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [TW-1:0] track_q, track_d;
   logic          ovf_q, ovf_d;

   logic          accept;
   logic          strobe;
   logic          full;
   logic          pop;
   logic          push;
   int unsigned   inflight;

   logic unused_supply;
   assign unused_supply = vdd ^ vss;

   // Credit check: slots already used plus operations still travelling the gate pipe
   always_comb begin
      inflight = 0;
      for (int i = 0; i < int'(TW); i++) begin
         inflight = inflight + 32'(track_q[i]);
      end
      bus.issue_ready = (32'(count_q) + inflight) < DEPTH;
   end

   always_comb begin
      accept = bus.issue & bus.issue_ready;
      strobe = (LAT > 1) ? track_q[TW-1] : accept;
      full   = (count_q == CW'(DEPTH));
      pop    = (count_q != '0) & bus.out_ready;
      push   = strobe & (~full | pop);
   end

   always_comb begin
      track_d  = '0;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;

      track_d[0] = (LAT > 1) ? accept : 1'b0;
      for (int i = 1; i < int'(TW); i++) begin
         track_d[i] = track_q[i-1];
      end

      if (push) begin
         mem_d[wr_ptr_q] = '{data: bus.alu_out,
                             zero: (bus.alu_out == '0),
                             neg:  bus.alu_out[WIDTH-1]};
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      ovf_d   = ovf_q | (strobe & full & ~pop);
   end

   always_ff @(posedge clkpos) begin
      if (rst) begin
         track_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         track_q  <= track_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // First-word fall-through view of the head entry
   always_comb begin
      bus.out_valid = (count_q != '0);
      bus.out_data  = mem_q[rd_ptr_q].data;
      bus.out_zero  = mem_q[rd_ptr_q].zero;
      bus.out_neg   = mem_q[rd_ptr_q].neg;
      bus.count     = count_q;
      bus.ovf_err   = ovf_q;
   end
endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo (WIDTH=16, DEPTH=4, LAT=2).
module tb_alu_result_fifo;
   logic clkpos = 1'b0;
   logic rst    = 1'b1;
   logic vdd    = 1'b1;
   logic vss    = 1'b0;

   int total = 0;
   int bad   = 0;
   int n_acc = 0;

   logic [17:0] exp_q[$];
   logic [17:0] mon_exp;
   logic [15:0] alu_next = 16'h5A5A;

   always #5 clkpos = ~clkpos;

   alu_result_fifo_if #(.WIDTH(16), .DEPTH(4)) bus ();

   alu_result_fifo #(.WIDTH(16), .DEPTH(4), .LAT(2)) dut (
      .clkpos (clkpos),
      .rst    (rst),
      .vdd    (vdd),
      .vss    (vss),
      .bus    (bus)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // One cycle of stimulus; the ALU result for an accepted issue appears one cycle later
   task automatic cyc(input logic iss, input logic [15:0] v, input logic rdy);
      @(posedge clkpos); #1;
      bus.alu_out   = alu_next;
      bus.out_ready = rdy;
      bus.issue     = iss;
      alu_next      = 16'h5A5A;
      if (iss && bus.issue_ready) begin
         exp_q.push_back({v, (v == 16'h0000), v[15]});
         alu_next = v;
         n_acc++;
      end
   endtask

   task automatic rst_pulse();
      @(posedge clkpos); #1;
      rst       = 1'b1;
      bus.issue = 1'b0;
      exp_q.delete();
      alu_next  = 16'h5A5A;
      @(posedge clkpos); #1;
      rst = 1'b0;
   endtask

   task automatic drain(input string nm);
      int k;
      k = 0;
      while (bus.count != 3'd0 && k < 20) begin
         cyc(1'b0, 16'h0000, 1'b1);
         k++;
      end
      chk(nm, 32'(bus.count), 32'd0);
   endtask

   // Monitor: every accepted head must match the oldest expected entry
   always @(negedge clkpos) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pop_unexpected actual=%h required=none",
                     {bus.out_data, bus.out_zero, bus.out_neg});
         end else begin
            mon_exp = exp_q.pop_front();
            if ({bus.out_data, bus.out_zero, bus.out_neg} !== mon_exp) begin
               bad++;
               $display("FAIL pop_data actual=%h required=%h",
                        {bus.out_data, bus.out_zero, bus.out_neg}, mon_exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      logic [15:0] b2b [8];
      b2b = '{16'h1234, 16'hFFFF, 16'h0000, 16'h8000,
              16'h7FFF, 16'h0001, 16'hA5A5, 16'h5A5A};
      bus.issue     = 1'b0;
      bus.out_ready = 1'b0;
      bus.alu_out   = 16'h0000;

      // Reset values
      rst_pulse();
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_ready", 32'(bus.issue_ready), 32'd1);
      chk("rst_ovf", 32'(bus.ovf_err), 32'd0);
      chk("rst_data", 32'({bus.out_data, bus.out_zero, bus.out_neg}), 32'd0);

      // Single op: issue cycle 0, valid in cycle 2
      cyc(1'b1, 16'h00F0, 1'b1);
      chk("single_c0_valid", 32'(bus.out_valid), 32'd0);
      cyc(1'b0, 16'h0000, 1'b1);
      chk("single_c1_valid", 32'(bus.out_valid), 32'd0);
      cyc(1'b0, 16'h0000, 1'b1);
      chk("single_c2_valid", 32'(bus.out_valid), 32'd1);
      chk("single_c2_data", 32'({bus.out_data, bus.out_zero, bus.out_neg}), 32'h003C0);
      cyc(1'b0, 16'h0000, 1'b1);
      chk("single_popped", 32'(bus.count), 32'd0);

      // Flags
      cyc(1'b1, 16'h0000, 1'b1);
      cyc(1'b1, 16'h8001, 1'b1);
      cyc(1'b0, 16'h0000, 1'b1);
      chk("flag_zero_entry", 32'({bus.out_data, bus.out_zero, bus.out_neg}), 32'h00002);
      cyc(1'b0, 16'h0000, 1'b1);
      chk("flag_neg_entry", 32'({bus.out_data, bus.out_zero, bus.out_neg}), 32'h20005);
      drain("flag_drain");

      // Credit gating with consumer stalled: values 1..4 accepted
      n0 = n_acc;
      for (int i = 0; i < 8; i++) cyc(1'b1, 16'(i + 1), 1'b0);
      chk("credit_accepted", 32'(n_acc - n0), 32'd4);
      cyc(1'b0, 16'h0000, 1'b0);
      chk("credit_count", 32'(bus.count), 32'd4);
      chk("credit_ready", 32'(bus.issue_ready), 32'd0);
      chk("credit_ovf", 32'(bus.ovf_err), 32'd0);

      // Full FIFO: forced capture of 5 coincides with pop of 1
      @(posedge clkpos); #1;
      bus.alu_out   = 16'h0005;
      bus.out_ready = 1'b1;
      force dut.track_q = 1'b1;
      exp_q.push_back({16'h0005, 1'b0, 1'b0});
      @(posedge clkpos); #1;
      force dut.track_q = 1'b0;
      bus.out_ready = 1'b0;
      chk("full_pp_count", 32'(bus.count), 32'd4);
      chk("full_pp_ovf", 32'(bus.ovf_err), 32'd0);
      chk("full_pp_head", 32'(bus.out_data), 32'h0002);
      @(posedge clkpos); #1;
      release dut.track_q;

      // Forced overflow: full, no pop -> dropped, sticky error
      @(posedge clkpos); #1;
      bus.alu_out = 16'h0BAD;
      force dut.track_q = 1'b1;
      @(posedge clkpos); #1;
      force dut.track_q = 1'b0;
      chk("ovf_set", 32'(bus.ovf_err), 32'd1);
      chk("ovf_count", 32'(bus.count), 32'd4);
      chk("ovf_head", 32'(bus.out_data), 32'h0002);
      @(posedge clkpos); #1;
      release dut.track_q;
      cyc(1'b0, 16'h0000, 1'b0);
      cyc(1'b0, 16'h0000, 1'b0);
      chk("ovf_sticky", 32'(bus.ovf_err), 32'd1);
      chk("full_ready_low", 32'(bus.issue_ready), 32'd0);

      // One pop reopens credit next cycle
      cyc(1'b0, 16'h0000, 1'b1);
      cyc(1'b0, 16'h0000, 1'b0);
      chk("pop_ready", 32'(bus.issue_ready), 32'd1);
      chk("pop_count", 32'(bus.count), 32'd3);
      drain("wrap_drain");

      // Back-to-back throughput
      n0 = n_acc;
      for (int i = 0; i < 8; i++) cyc(1'b1, b2b[i], 1'b1);
      chk("b2b_accepted", 32'(n_acc - n0), 32'd8);
      chk("b2b_count", 32'(bus.count), 32'd1);
      drain("b2b_drain");
      chk("ovf_still_set", 32'(bus.ovf_err), 32'd1);

      // Reset mid-flight
      cyc(1'b1, 16'h1111, 1'b0);
      cyc(1'b1, 16'h2222, 1'b0);
      rst_pulse();
      chk("midrst_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_count", 32'(bus.count), 32'd0);
      chk("midrst_ready", 32'(bus.issue_ready), 32'd1);
      chk("midrst_ovf", 32'(bus.ovf_err), 32'd0);
      cyc(1'b0, 16'h0000, 1'b0);
      cyc(1'b0, 16'h0000, 1'b0);
      chk("midrst_nocapture", 32'(bus.count), 32'd0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
